run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
- Synthesizable run-control block between the board/bench clock-reset source and the single-cycle RISC-V core.
- Holds the core in reset for a programmable number of cycles, then gates execution in free-run or single-step mode.
- Counts cycles and retired instructions, and stops the core on ebreak/ecall, on a jump-to-self, or on a cycle budget timeout.
- Replaces fixed-duration simulation runs with a deterministic, observable end-of-program condition.

Parameters:
XLEN, 32, width of PC and count outputs
RESET_CYCLES, 4, cycles core_rst_n is held low after start (min 1)
MAX_CYCLES, 1000, run-cycle budget before timeout (0 = no timeout)
CNT_W, 32, width of cycle_cnt and instret_cnt

Ports:
CLK  input  1  system clock, rising-edge
RST_N  input  1  asynchronous active-low reset
start  input  1  level/pulse; sampled in IDLE or HALTED to begin a run
step_mode  input  1  1 = single-step, 0 = free-run; sampled every cycle in RUN/STEP
step_req  input  1  one-cycle pulse; grants one instruction in step mode
instr  input  32  instruction currently fetched by core
pc  input  XLEN  current PC of core
core_rst_n  output  1  active-low reset to core
core_en  output  1  clock-enable / commit enable to core (PC and regfile update only when 1)
cycle_cnt  output  CNT_W  cycles spent in RUN/STEP since start
instret_cnt  output  CNT_W  instructions committed (core_en high cycles)
done  output  1  high in HALTED after a halt instruction or self-loop
timeout  output  1  high in HALTED after budget exhaustion
halt_pc  output  XLEN  PC captured at halt

Behaviour:
- Reset (RST_N low, async): state IDLE; core_rst_n=0, core_en=0, cycle_cnt=0, instret_cnt=0, done=0, timeout=0, halt_pc=0. Deassertion is internally synchronised with a 2-flop synchroniser; first state change occurs no earlier than the 2nd rising edge after release.
- States: IDLE, RESET, RUN, STEP, HALTED. All outputs are registered.
- IDLE: core_rst_n=0. On start=1 -> RESET; counters and flags cleared the same edge.
- RESET: core_rst_n=0 for exactly RESET_CYCLES cycles (internal down-counter). Then -> RUN if step_mode=0, else STEP. core_rst_n=1 from the first cycle of RUN/STEP.
- RUN: core_en=1; cycle_cnt and instret_cnt increment every cycle. step_mode=1 -> STEP on the next edge (the current instruction still commits).
- STEP: core_en=1 only in the cycle after a step_req pulse (one instruction per pulse); cycle_cnt increments every cycle, instret_cnt only when core_en=1. step_mode=0 -> RUN.
  - step_req in RUN is ignored.
  - step_req held high for N cycles grants N instructions.
- Halt detect, evaluated in RUN/STEP only when core_en=1 for that cycle:
  - instr == 0x00100073 (ebreak) or 0x00000073 (ecall), or instr == 0x0000006F (jal x0,0): the instruction does not commit (core_en forced 0 that cycle combinationally from the registered detect path); halt_pc<=pc; done<=1; -> HALTED.
  - instret_cnt does not count the halting instruction.
- Timeout: if MAX_CYCLES!=0 and cycle_cnt reaches MAX_CYCLES-1 while in RUN/STEP: timeout<=1, halt_pc<=pc, -> HALTED.
  - If the halt instruction and the timeout coincide, done wins: done=1, timeout=0.
- HALTED: core_en=0, core_rst_n stays 1 (core state remains inspectable); counters frozen; done/timeout held. start=1 -> RESET (restart; flags and counters cleared).
- Counters saturate at all-ones and do not wrap.
- start while in RESET/RUN/STEP is ignored.
- RST_N asserted mid-run: immediate return to reset values regardless of state; core_rst_n drops asynchronously the same instant.

Test Plan:
- Reset/start: RST_N low then high, start pulse, RESET_CYCLES=4 -> core_rst_n low exactly 4 cycles after RESET entry, then core_en=1 and cycle_cnt increments 1 per cycle.
- Ebreak halt: free-run, present instr=0x00100073 at pc=0x24 after 9 committed instrs -> done=1, timeout=0, halt_pc=0x24, instret_cnt=9, core_en=0 thereafter, counters frozen.
- Timeout: MAX_CYCLES=25, instr never a halt pattern -> HALTED with timeout=1, done=0, cycle_cnt=25 (no further increments); same-cycle ebreak case -> done=1, timeout=0.
- Single step: step_mode=1, three step_req pulses spaced 5 cycles apart -> exactly 3 core_en-high cycles, instret_cnt=3, cycle_cnt=RUN/STEP cycle count; toggle step_mode=0 -> continuous core_en.
- Restart and async reset: from HALTED pulse start -> counters/flags clear, RESET sequence repeats; assert RST_N mid-RUN between clock edges -> core_rst_n=0 and all outputs at reset values before the next edge.
- Saturation: CNT_W=4, MAX_CYCLES=0, run 20 cycles -> cycle_cnt holds 15.

Source files
------------

// File: rtl/run_controller.sv
// run_controller: sequences reset and execution of a single-cycle core.
// It holds the core in reset for RESET_CYCLES cycles and then lets it run
// freely or one instruction per step request. It counts cycles and retired
// instructions, and halts on ebreak, ecall, a jump-to-self or when the cycle
// budget runs out.
module run_controller #(
    parameter int XLEN         = 32,
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CYCLES   = 1000,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    output logic             core_rst_n,
    output logic             core_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output logic             done,
    output logic             timeout,
    output logic [XLEN-1:0]  halt_pc
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_RUN    = 3'd2,
        S_STEP   = 3'd3,
        S_HALTED = 3'd4
    } state_e;

    localparam int              RC_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RESET_CYCLES - 1);
    localparam bit              TO_EN   = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MAX_CYCLES != 0) ? (MAX_CYCLES - 1) : 0);

    // ebreak, ecall and "jal x0, 0" all end the program
    function automatic logic is_halt_instr(input logic [31:0] i);
        return (i == 32'h0010_0073) || (i == 32'h0000_0073) || (i == 32'h0000_006F);
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        if (en && (c != {CNT_W{1'b1}})) begin
            return c + CNT_W'(1);
        end else begin
            return c;
        end
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        sync_q;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              core_en_q, core_en_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic [XLEN-1:0]   halt_pc_q, halt_pc_d;

    logic rst_ok_s;
    logic active_s;
    logic halt_hit_s;
    logic to_hit_s;
    logic commit_s;

    assign rst_ok_s   = sync_q[1];
    assign active_s   = (state_q == S_RUN) || (state_q == S_STEP);
    // Halt detection only looks at instructions that were granted this cycle
    assign halt_hit_s = active_s && core_en_q && is_halt_instr(instr);
    assign to_hit_s   = TO_EN && active_s && (cycle_q == TO_LAST);
    // A halting instruction is suppressed so the core state stays at the halt point
    assign commit_s   = core_en_q && !halt_hit_s;

    assign core_rst_n  = core_rst_n_q;
    assign core_en     = commit_s;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign halt_pc     = halt_pc_q;

    // Two-flop synchroniser for the release edge of RST_N
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    // Next-state and next-output logic of the run-control FSM
    always_comb begin
        state_d      = state_q;
        rc_d         = rc_q;
        core_rst_n_d = core_rst_n_q;
        core_en_d    = 1'b0;
        cycle_d      = cycle_q;
        instret_d    = instret_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        halt_pc_d    = halt_pc_q;
        if (!rst_ok_s) begin
            state_d      = S_IDLE;
            core_rst_n_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state_d      = S_RESET;
                        rc_d         = RC_LOAD;
                        core_rst_n_d = 1'b0;
                        cycle_d      = {CNT_W{1'b0}};
                        instret_d    = {CNT_W{1'b0}};
                        done_d       = 1'b0;
                        timeout_d    = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_RESET: begin
                    core_rst_n_d = 1'b0;
                    if (rc_q == {RC_W{1'b0}}) begin
                        core_rst_n_d = 1'b1;
                        if (step_mode) begin
                            state_d = S_STEP;
                        end else begin
                            state_d   = S_RUN;
                            core_en_d = 1'b1;
                        end
                    end else begin
                        rc_d = rc_q - RC_W'(1);
                    end
                end
                S_RUN, S_STEP: begin
                    cycle_d   = sat_inc(cycle_q, 1'b1);
                    instret_d = sat_inc(instret_q, commit_s);
                    if (halt_hit_s) begin
                        done_d    = 1'b1;
                        halt_pc_d = pc;
                        state_d   = S_HALTED;
                    end else if (to_hit_s) begin
                        timeout_d = 1'b1;
                        halt_pc_d = pc;
                        state_d   = S_HALTED;
                    end else if (step_mode) begin
                        // Step requests count only once already in STEP
                        state_d   = S_STEP;
                        core_en_d = (state_q == S_STEP) ? step_req : 1'b0;
                    end else begin
                        state_d   = S_RUN;
                        core_en_d = 1'b1;
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    core_rst_n_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers, cleared immediately by RST_N
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            rc_q         <= {RC_W{1'b0}};
            core_rst_n_q <= 1'b0;
            core_en_q    <= 1'b0;
            cycle_q      <= {CNT_W{1'b0}};
            instret_q    <= {CNT_W{1'b0}};
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            halt_pc_q    <= {XLEN{1'b0}};
        end else begin
            state_q      <= state_d;
            rc_q         <= rc_d;
            core_rst_n_q <= core_rst_n_d;
            core_en_q    <= core_en_d;
            cycle_q      <= cycle_d;
            instret_q    <= instret_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            halt_pc_q    <= halt_pc_d;
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// Directed testbench for run_controller. Three instances share the stimulus:
// dut_a uses default parameters, dut_t has a 25-cycle budget and dut_s has
// 4-bit counters with no budget.
module tb_run_controller;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        step_mode;
    logic        step_req;
    logic [31:0] instr;
    logic [31:0] pc;

    logic        core_rst_n_a, core_en_a, done_a, timeout_a;
    logic [31:0] cycle_a, instret_a, halt_pc_a;
    logic        core_rst_n_t, core_en_t, done_t, timeout_t;
    logic [31:0] cycle_t, instret_t, halt_pc_t;
    logic        core_rst_n_s, core_en_s, done_s, timeout_s;
    logic [3:0]  cycle_s, instret_s;
    logic [31:0] halt_pc_s;

    int n_vec = 0;
    int n_err = 0;

    run_controller dut_a (
        .CLK(clk), .RST_N(rst_n), .start(start), .step_mode(step_mode),
        .step_req(step_req), .instr(instr), .pc(pc),
        .core_rst_n(core_rst_n_a), .core_en(core_en_a), .cycle_cnt(cycle_a),
        .instret_cnt(instret_a), .done(done_a), .timeout(timeout_a), .halt_pc(halt_pc_a)
    );

    run_controller #(.MAX_CYCLES(25)) dut_t (
        .CLK(clk), .RST_N(rst_n), .start(start), .step_mode(step_mode),
        .step_req(step_req), .instr(instr), .pc(pc),
        .core_rst_n(core_rst_n_t), .core_en(core_en_t), .cycle_cnt(cycle_t),
        .instret_cnt(instret_t), .done(done_t), .timeout(timeout_t), .halt_pc(halt_pc_t)
    );

    run_controller #(.CNT_W(4), .MAX_CYCLES(0)) dut_s (
        .CLK(clk), .RST_N(rst_n), .start(start), .step_mode(step_mode),
        .step_req(step_req), .instr(instr), .pc(pc),
        .core_rst_n(core_rst_n_s), .core_en(core_en_s), .cycle_cnt(cycle_s),
        .instret_cnt(instret_s), .done(done_s), .timeout(timeout_s), .halt_pc(halt_pc_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        instr = NOP; pc = 32'h0;
        #3;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic go_run(input logic mode);
        do_reset();
        step_mode = mode;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_start();
        int n;
        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        instr = NOP; pc = 32'h0;
        #7;
        n_vec++; if (core_rst_n_a !== 1'b0) begin n_err++; $display("FAIL rst_core_rst_n got %0b exp 0", core_rst_n_a); end
        n_vec++; if (core_en_a !== 1'b0) begin n_err++; $display("FAIL rst_core_en got %0b exp 0", core_en_a); end
        n_vec++; if (cycle_a !== 32'd0) begin n_err++; $display("FAIL rst_cycle got %0d exp 0", cycle_a); end
        n_vec++; if (instret_a !== 32'd0) begin n_err++; $display("FAIL rst_instret got %0d exp 0", instret_a); end
        n_vec++; if (done_a !== 1'b0 || timeout_a !== 1'b0) begin n_err++; $display("FAIL rst_flags got %0b%0b exp 00", done_a, timeout_a); end
        n_vec++; if (halt_pc_a !== 32'd0) begin n_err++; $display("FAIL rst_halt_pc got %h exp 0", halt_pc_a); end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (core_rst_n_a === 1'b0 && n < 20) begin
            n++;
            tick();
        end
        n_vec++; if (n != 4) begin n_err++; $display("FAIL reset_len got %0d exp 4", n); end
        n_vec++; if (core_en_a !== 1'b1) begin n_err++; $display("FAIL run_core_en got %0b exp 1", core_en_a); end
        n_vec++; if (cycle_a !== 32'd0) begin n_err++; $display("FAIL run_cycle0 got %0d exp 0", cycle_a); end
        tick();
        n_vec++; if (cycle_a !== 32'd1) begin n_err++; $display("FAIL run_cycle1 got %0d exp 1", cycle_a); end
        tick();
        n_vec++; if (cycle_a !== 32'd2 || instret_a !== 32'd2) begin n_err++; $display("FAIL run_cycle2 got %0d/%0d exp 2/2", cycle_a, instret_a); end
    endtask

    task automatic test_ebreak();
        go_run(1'b0);
        repeat (9) tick();
        n_vec++; if (instret_a !== 32'd9) begin n_err++; $display("FAIL pre_halt_instret got %0d exp 9", instret_a); end
        instr = EBREAK; pc = 32'h24;
        #1;
        n_vec++; if (core_en_a !== 1'b0) begin n_err++; $display("FAIL ebreak_suppress got %0b exp 0", core_en_a); end
        tick();
        instr = NOP; pc = 32'h28;
        n_vec++; if (done_a !== 1'b1 || timeout_a !== 1'b0) begin n_err++; $display("FAIL ebreak_flags got %0b%0b exp 10", done_a, timeout_a); end
        n_vec++; if (halt_pc_a !== 32'h24) begin n_err++; $display("FAIL ebreak_halt_pc got %h exp 24", halt_pc_a); end
        n_vec++; if (instret_a !== 32'd9 || cycle_a !== 32'd10) begin n_err++; $display("FAIL ebreak_counts got %0d/%0d exp 9/10", instret_a, cycle_a); end
        repeat (3) tick();
        n_vec++; if (core_en_a !== 1'b0 || core_rst_n_a !== 1'b1) begin n_err++; $display("FAIL halted_ctrl got en %0b rst_n %0b exp 0 1", core_en_a, core_rst_n_a); end
        n_vec++; if (instret_a !== 32'd9 || cycle_a !== 32'd10 || done_a !== 1'b1) begin n_err++; $display("FAIL halted_frozen got %0d/%0d done %0b exp 9/10 1", instret_a, cycle_a, done_a); end
    endtask

    task automatic test_timeout();
        int n;
        go_run(1'b0);
        pc = 32'h80;
        n = 0;
        while (timeout_t !== 1'b1 && n < 100) begin
            n++;
            tick();
        end
        n_vec++; if (n != 25) begin n_err++; $display("FAIL timeout_ticks got %0d exp 25", n); end
        n_vec++; if (done_t !== 1'b0 || timeout_t !== 1'b1) begin n_err++; $display("FAIL timeout_flags got %0b%0b exp 01", done_t, timeout_t); end
        n_vec++; if (cycle_t !== 32'd25 || halt_pc_t !== 32'h80) begin n_err++; $display("FAIL timeout_cycle got %0d pc %h exp 25 80", cycle_t, halt_pc_t); end
        repeat (4) tick();
        n_vec++; if (cycle_t !== 32'd25 || core_en_t !== 1'b0) begin n_err++; $display("FAIL timeout_frozen got %0d en %0b exp 25 0", cycle_t, core_en_t); end
        // ebreak arriving on the last budget cycle
        go_run(1'b0);
        repeat (24) tick();
        instr = EBREAK; pc = 32'h40;
        tick();
        instr = NOP;
        n_vec++; if (done_t !== 1'b1 || timeout_t !== 1'b0) begin n_err++; $display("FAIL coincide_flags got %0b%0b exp 10", done_t, timeout_t); end
        n_vec++; if (halt_pc_t !== 32'h40 || instret_t !== 32'd24) begin n_err++; $display("FAIL coincide_state got %h/%0d exp 40/24", halt_pc_t, instret_t); end
    endtask

    task automatic test_single_step();
        int en_cnt;
        go_run(1'b1);
        n_vec++; if (core_en_a !== 1'b0 || core_rst_n_a !== 1'b1) begin n_err++; $display("FAIL step_entry got en %0b rst_n %0b exp 0 1", core_en_a, core_rst_n_a); end
        en_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step_req = ((i % 5) == 0);
            tick();
            if (core_en_a === 1'b1) en_cnt++;
        end
        step_req = 1'b0;
        n_vec++; if (en_cnt != 3) begin n_err++; $display("FAIL step_grants got %0d exp 3", en_cnt); end
        n_vec++; if (instret_a !== 32'd3 || cycle_a !== 32'd15) begin n_err++; $display("FAIL step_counts got %0d/%0d exp 3/15", instret_a, cycle_a); end
        step_req = 1'b1;
        repeat (3) tick();
        step_req = 1'b0;
        tick();
        n_vec++; if (instret_a !== 32'd6 || core_en_a !== 1'b0) begin n_err++; $display("FAIL step_held got %0d en %0b exp 6 0", instret_a, core_en_a); end
        step_mode = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (core_en_a === 1'b1) en_cnt++;
        end
        n_vec++; if (en_cnt != 3) begin n_err++; $display("FAIL freerun_en got %0d exp 3", en_cnt); end
        n_vec++; if (instret_a !== 32'd8 || cycle_a !== 32'd22) begin n_err++; $display("FAIL freerun_counts got %0d/%0d exp 8/22", instret_a, cycle_a); end
    endtask

    task automatic test_restart_async();
        int n;
        go_run(1'b0);
        repeat (3) tick();
        instr = EBREAK; pc = 32'h10;
        tick();
        instr = NOP;
        n_vec++; if (done_a !== 1'b1) begin n_err++; $display("FAIL restart_pre_done got %0b exp 1", done_a); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++; if (done_a !== 1'b0 || cycle_a !== 32'd0 || instret_a !== 32'd0) begin n_err++; $display("FAIL restart_clear got done %0b %0d/%0d exp 0 0/0", done_a, cycle_a, instret_a); end
        n = 0;
        while (core_rst_n_a === 1'b0 && n < 20) begin
            n++;
            tick();
        end
        n_vec++; if (n != 4) begin n_err++; $display("FAIL restart_reset_len got %0d exp 4", n); end
        repeat (3) tick();
        n_vec++; if (cycle_a !== 32'd3 || core_en_a !== 1'b1) begin n_err++; $display("FAIL restart_run got %0d en %0b exp 3 1", cycle_a, core_en_a); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (core_rst_n_a !== 1'b0 || core_en_a !== 1'b0) begin n_err++; $display("FAIL async_ctrl got rst_n %0b en %0b exp 0 0", core_rst_n_a, core_en_a); end
        n_vec++; if (cycle_a !== 32'd0 || instret_a !== 32'd0 || halt_pc_a !== 32'd0) begin n_err++; $display("FAIL async_regs got %0d/%0d pc %h exp 0/0 0", cycle_a, instret_a, halt_pc_a); end
    endtask

    task automatic test_saturation();
        go_run(1'b0);
        repeat (20) tick();
        n_vec++; if (cycle_s !== 4'd15 || instret_s !== 4'd15) begin n_err++; $display("FAIL sat_counts got %0d/%0d exp 15/15", cycle_s, instret_s); end
        n_vec++; if (timeout_s !== 1'b0 || core_en_s !== 1'b1) begin n_err++; $display("FAIL sat_running got to %0b en %0b exp 0 1", timeout_s, core_en_s); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset_start();
        test_ebreak();
        test_timeout();
        test_single_step();
        test_restart_async();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
